// File: rtl/mp_job_fetch.sv
// Per-process job-descriptor fetcher: a PID-indexed pointer table drives single-beat
// 128-byte AXI4 reads whose data is handed downstream together with the PID.
module mp_job_fetch #(
    parameter int ID_WIDTH     = 1,
    parameter int ARUSER_WIDTH = 9,
    parameter int DATA_WIDTH   = 1024,
    parameter int ADDR_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8:0]              job_ram_addr_i,
    input  logic                    job_ram_hi_i,
    input  logic                    job_ram_lo_i,
    input  logic [31:0]             job_ram_data_i,
    output logic                    fetch_ready_o,
    input  logic                    fetch_push_i,
    input  logic [8:0]              fetch_pid_i,
    output logic                    desc_valid_o,
    input  logic                    desc_ready_i,
    output logic [DATA_WIDTH-1:0]   desc_data_o,
    output logic [8:0]              desc_pid_o,
    output logic                    desc_err_o,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [3:0]              m_axi_arcache,
    output logic                    m_axi_arlock,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_OUT  = 3'd3,
        S_UPD  = 3'd4
    } state_t;

    state_t state_r, state_nxt_s;

    logic [8:0]  fifo_mem_r [0:7];
    logic [2:0]  fifo_wr_ptr_r, fifo_rd_ptr_r;
    logic [3:0]  fifo_cnt_r;
    logic        fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    logic [8:0]  fifo_head_s;

    logic [31:0] ptr_lo_mem_r [0:511];
    logic [31:0] ptr_hi_mem_r [0:511];
    logic        mmio_wr_s, upd_we_s, stale_hit_s;
    logic [63:0] ptr_next_s;

    logic [8:0]            pid_r;
    logic [63:0]           araddr_r;
    logic                  stale_r;
    logic [DATA_WIDTH-1:0] desc_data_r;
    logic                  desc_err_r;
    logic                  arvalid_s, rready_s, desc_valid_s;
    logic                  unused_s;

    assign fifo_full_s  = (fifo_cnt_r == 4'd8);
    assign fifo_empty_s = (fifo_cnt_r == 4'd0);
    assign fifo_push_s  = fetch_push_i && !fifo_full_s;
    assign fifo_head_s  = fifo_mem_r[fifo_rd_ptr_r];

    assign mmio_wr_s   = job_ram_hi_i || job_ram_lo_i;
    // Software re-pointing the in-flight PID must win over the post-fetch advance.
    assign stale_hit_s = mmio_wr_s && (job_ram_addr_i == pid_r) &&
                         ((state_r == S_AR) || (state_r == S_R) || (state_r == S_OUT));
    assign ptr_next_s  = araddr_r + 64'd128;

    // Request FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= fetch_pid_i;
        end
    end

    // Request FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr_r <= 3'd0;
            fifo_rd_ptr_r <= 3'd0;
            fifo_cnt_r    <= 4'd0;
        end else begin
            if (fifo_push_s) fifo_wr_ptr_r <= fifo_wr_ptr_r + 3'd1;
            if (fifo_pop_s)  fifo_rd_ptr_r <= fifo_rd_ptr_r + 3'd1;
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 4'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 4'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Pointer table halves; MMIO beats the advance write, which waits in UPD.
    always_ff @(posedge clk) begin
        if (job_ram_lo_i) begin
            ptr_lo_mem_r[job_ram_addr_i] <= job_ram_data_i;
        end else if (upd_we_s) begin
            ptr_lo_mem_r[pid_r] <= ptr_next_s[31:0];
        end
        if (job_ram_hi_i) begin
            ptr_hi_mem_r[job_ram_addr_i] <= job_ram_data_i;
        end else if (upd_we_s) begin
            ptr_hi_mem_r[pid_r] <= ptr_next_s[63:32];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) state_nxt_s = S_AR;
                else               state_nxt_s = S_IDLE;
            end
            S_AR: begin
                if (m_axi_arready) state_nxt_s = S_R;
                else               state_nxt_s = S_AR;
            end
            S_R: begin
                if (m_axi_rvalid) state_nxt_s = S_OUT;
                else              state_nxt_s = S_R;
            end
            S_OUT: begin
                if (desc_ready_i) begin
                    if (!desc_err_r && !stale_r) state_nxt_s = S_UPD;
                    else                         state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            S_UPD: begin
                if (mmio_wr_s) state_nxt_s = S_UPD;
                else           state_nxt_s = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode from the state register.
    always_comb begin
        fifo_pop_s   = 1'b0;
        arvalid_s    = 1'b0;
        rready_s     = 1'b0;
        desc_valid_s = 1'b0;
        upd_we_s     = 1'b0;
        case (state_r)
            S_IDLE:  fifo_pop_s   = !fifo_empty_s;
            S_AR:    arvalid_s    = 1'b1;
            S_R:     rready_s     = 1'b1;
            S_OUT:   desc_valid_s = 1'b1;
            S_UPD:   upd_we_s     = !mmio_wr_s;
            default: fifo_pop_s   = 1'b0;
        endcase
    end

    // Per-transaction context and captured descriptor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_r       <= 9'd0;
            araddr_r    <= 64'd0;
            stale_r     <= 1'b0;
            desc_data_r <= {DATA_WIDTH{1'b0}};
            desc_err_r  <= 1'b0;
        end else begin
            if (fifo_pop_s) begin
                pid_r    <= fifo_head_s;
                araddr_r <= {ptr_hi_mem_r[fifo_head_s], ptr_lo_mem_r[fifo_head_s]};
                stale_r  <= 1'b0;
            end else if (stale_hit_s) begin
                stale_r  <= 1'b1;
            end
            if (rready_s && m_axi_rvalid) begin
                desc_data_r <= m_axi_rdata;
                desc_err_r  <= (m_axi_rresp != 2'b00);
            end
        end
    end

    assign fetch_ready_o = !fifo_full_s;
    assign desc_valid_o  = desc_valid_s;
    assign desc_data_o   = desc_data_r;
    assign desc_pid_o    = pid_r;
    assign desc_err_o    = desc_err_r;

    assign m_axi_arid    = {ID_WIDTH{1'b0}};
    assign m_axi_araddr  = ADDR_WIDTH'(araddr_r);
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd7;
    assign m_axi_arburst = 2'd1;
    assign m_axi_arcache = 4'd3;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_aruser  = ARUSER_WIDTH'(pid_r);
    assign m_axi_arvalid = arvalid_s;
    assign m_axi_rready  = rready_s;

    // Single-beat reads: rid and rlast carry no information here.
    assign unused_s = ^{m_axi_rid, m_axi_rlast};

endmodule

// File: tb/tb_mp_job_fetch.sv
// Scoreboard bench for mp_job_fetch: a reference pointer table predicts each AR address,
// a simple AXI slave answers, and every descriptor is checked in order.
module tb_mp_job_fetch;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8:0]    job_ram_addr_i;
    logic          job_ram_hi_i, job_ram_lo_i;
    logic [31:0]   job_ram_data_i;
    logic          fetch_ready_o, fetch_push_i;
    logic [8:0]    fetch_pid_i;
    logic          desc_valid_o, desc_ready_i, desc_err_o;
    logic [1023:0] desc_data_o;
    logic [8:0]    desc_pid_o;
    logic [0:0]    m_axi_arid, m_axi_rid;
    logic [63:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize, m_axi_arprot;
    logic [1:0]    m_axi_arburst, m_axi_rresp;
    logic [3:0]    m_axi_arcache, m_axi_arqos;
    logic          m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [8:0]    m_axi_aruser;
    logic [1023:0] m_axi_rdata;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    mp_job_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .job_ram_addr_i(job_ram_addr_i), .job_ram_hi_i(job_ram_hi_i),
        .job_ram_lo_i(job_ram_lo_i), .job_ram_data_i(job_ram_data_i),
        .fetch_ready_o(fetch_ready_o), .fetch_push_i(fetch_push_i), .fetch_pid_i(fetch_pid_i),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_data_o(desc_data_o),
        .desc_pid_o(desc_pid_o), .desc_err_o(desc_err_o),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
        .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct packed {
        logic [8:0]  pid;
        logic [63:0] addr;
        logic        err;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_ptr [0:511];
    logic [8:0]  ar_q [$];
    exp_t        desc_q [$];
    logic [8:0]  err_pid = 9'h1ff;
    bit          stale_pend = 1'b0;
    bit          ar_en = 1'b1;
    int          r_lat = 0;
    int          ar_cnt = 0;
    int          outstanding = 0;
    bit          ar_fire = 1'b0, r_fire = 1'b0;
    logic [63:0] sl_addr;
    logic [8:0]  sl_pid;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [1023:0] mk_data(input logic [63:0] a);
        logic [1023:0] d;
        for (int i = 0; i < 16; i++) d[i*64 +: 64] = a ^ (64'h0123_4567_89AB_CDEF * 64'(i + 1));
        return d;
    endfunction

    // Monitor: handshakes seen here complete on the following rising edge.
    initial begin
        exp_t          e;
        logic [8:0]    p;
        logic [1023:0] d;
        forever begin
            @(negedge clk);
            ar_fire = 1'b0;
            r_fire  = 1'b0;
            if (rst_n) begin
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_fire = 1'b1;
                    ar_cnt++;
                    check_eq("one_outstanding", 128'(outstanding), 128'd0);
                    outstanding++;
                    sl_addr = m_axi_araddr;
                    sl_pid  = m_axi_aruser;
                    check_eq("ar_const",
                        128'({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                              m_axi_arcache, m_axi_arlock, m_axi_arprot, m_axi_arqos}),
                        128'({1'b0, 8'h00, 3'd7, 2'd1, 4'd3, 1'b0, 3'd0, 4'd0}));
                    check_eq("ar_expected", 128'(ar_q.size() != 0), 128'd1);
                    if (ar_q.size() != 0) begin
                        p = ar_q.pop_front();
                        check_eq("araddr", 128'(m_axi_araddr), 128'(model_ptr[p]));
                        check_eq("aruser", 128'(m_axi_aruser), 128'(p));
                        desc_q.push_back('{pid: p, addr: model_ptr[p], err: (p == err_pid)});
                    end
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    r_fire = 1'b1;
                    outstanding--;
                end
                if (desc_valid_o && desc_ready_i) begin
                    check_eq("desc_expected", 128'(desc_q.size() != 0), 128'd1);
                    if (desc_q.size() != 0) begin
                        e = desc_q.pop_front();
                        check_eq("desc_pid", 128'(desc_pid_o), 128'(e.pid));
                        check_eq("desc_err", 128'(desc_err_o), 128'(e.err));
                        if (!e.err) begin
                            d = mk_data(e.addr);
                            for (int i = 0; i < 8; i++)
                                check_eq("desc_data", desc_data_o[i*128 +: 128], d[i*128 +: 128]);
                            if (!stale_pend) model_ptr[e.pid] = e.addr + 64'd128;
                        end
                        stale_pend = 1'b0;
                    end
                end
            end
        end
    end

    // AXI read slave: constant arready level, one response per accepted address.
    initial begin
        bit sl_pend;
        int sl_wait;
        sl_pend = 1'b0;
        sl_wait = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rid = 1'b0; m_axi_rlast = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                sl_pend       = 1'b0;
            end else begin
                if (r_fire) m_axi_rvalid = 1'b0;
                if (ar_fire) begin
                    sl_pend = 1'b1;
                    sl_wait = r_lat;
                end
                if (sl_pend && !m_axi_rvalid) begin
                    if (sl_wait == 0) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = mk_data(sl_addr);
                        m_axi_rresp  = (sl_pid == err_pid) ? 2'b10 : 2'b00;
                        sl_pend      = 1'b0;
                    end else begin
                        sl_wait--;
                    end
                end
                m_axi_arready = ar_en;
            end
        end
    end

    task automatic mmio_wr(input logic [8:0] pid, input bit hi, input logic [31:0] data);
        job_ram_addr_i = pid;
        job_ram_data_i = data;
        job_ram_hi_i   = hi;
        job_ram_lo_i   = !hi;
        if (hi) model_ptr[pid][63:32] = data;
        else    model_ptr[pid][31:0]  = data;
        @(posedge clk);
        #1;
        job_ram_hi_i = 1'b0;
        job_ram_lo_i = 1'b0;
    endtask

    task automatic set_ptr(input logic [8:0] pid, input logic [63:0] ptr);
        mmio_wr(pid, 1'b0, ptr[31:0]);
        mmio_wr(pid, 1'b1, ptr[63:32]);
    endtask

    task automatic push(input logic [8:0] pid);
        if (fetch_ready_o) ar_q.push_back(pid);
        fetch_push_i = 1'b1;
        fetch_pid_i  = pid;
        @(posedge clk);
        #1;
        fetch_push_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((ar_q.size() != 0 || desc_q.size() != 0) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("drain_done", 128'(ar_q.size() + desc_q.size()), 128'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_desc(input string tag);
        int t = 0;
        while (!desc_valid_o && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq(tag, 128'(desc_valid_o), 128'd1);
    endtask

    // Accept one descriptor, optionally colliding an MMIO write with UPD; n counts edges to arvalid.
    task automatic deliver_one(input bit collide, output int n);
        wait_desc("deliver_valid");
        desc_ready_i = 1'b1;
        @(posedge clk);
        #1;
        desc_ready_i = 1'b0;
        if (collide) begin
            job_ram_addr_i = 9'd40;
            job_ram_data_i = 32'h0000_5000;
            job_ram_lo_i   = 1'b1;
            model_ptr[40][31:0] = 32'h0000_5000;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            job_ram_lo_i = 1'b0;
        end while (!m_axi_arvalid && n < 20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saved;
        rst_n = 1'b0;
        job_ram_addr_i = 9'd0; job_ram_hi_i = 1'b0; job_ram_lo_i = 1'b0; job_ram_data_i = 32'd0;
        fetch_push_i = 1'b0; fetch_pid_i = 9'd0; desc_ready_i = 1'b0;
        for (int i = 0; i < 512; i++) model_ptr[i] = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_arvalid", 128'(m_axi_arvalid), 128'd0);
        check_eq("rst_rready", 128'(m_axi_rready), 128'd0);
        check_eq("rst_desc_valid", 128'(desc_valid_o), 128'd0);
        check_eq("rst_desc_err", 128'(desc_err_o), 128'd0);
        check_eq("rst_desc_pid", 128'(desc_pid_o), 128'd0);
        check_eq("rst_desc_data", 128'(|desc_data_o), 128'd0);
        check_eq("rst_araddr", 128'(m_axi_araddr), 128'd0);
        check_eq("rst_fetch_ready", 128'(fetch_ready_o), 128'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry from lo into hi on the advance.
        set_ptr(9'd5, 64'h0000_0001_FFFF_FF80);
        desc_ready_i = 1'b1;
        push(9'd5);
        check_eq("push_ar_gap1", 128'(m_axi_arvalid), 128'd0);
        @(posedge clk);
        #1;
        check_eq("push_ar_gap2", 128'(m_axi_arvalid), 128'd1);
        drain();
        push(9'd5);
        drain();

        // Back-to-back requests with a stalled consumer.
        desc_ready_i = 1'b0;
        for (int p = 1; p <= 3; p++) set_ptr(9'(p), 64'h1000);
        for (int p = 1; p <= 3; p++) push(9'(p));
        wait_desc("hold_first_valid");
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_valid", 128'(desc_valid_o), 128'd1);
            check_eq("hold_pid", 128'(desc_pid_o), 128'd1);
            check_eq("hold_no_ar", 128'(m_axi_arvalid), 128'd0);
            @(posedge clk);
            #1;
        end
        desc_ready_i = 1'b1;
        drain();
        for (int p = 1; p <= 3; p++) push(9'(p));
        drain();

        // Error response leaves the pointer alone.
        err_pid = 9'd7;
        set_ptr(9'd7, 64'h4000);
        push(9'd7);
        drain();
        push(9'd7);
        drain();
        err_pid = 9'h1ff;

        // Re-pointing during R wins over the advance.
        set_ptr(9'd9, 64'h0000_0003_0000_2000);
        r_lat = 6;
        push(9'd9);
        n = 0;
        while (!m_axi_rready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("in_r_state", 128'(m_axi_rready), 128'd1);
        stale_pend = 1'b1;
        mmio_wr(9'd9, 1'b0, 32'h0000_8000);
        check_eq("araddr_hold", 128'(m_axi_araddr), 128'h3_0000_2000);
        drain();
        r_lat = 0;
        push(9'd9);
        drain();

        // FIFO full with AR blocked, then UPD/MMIO collision.
        desc_ready_i = 1'b0;
        for (int p = 20; p <= 29; p++) set_ptr(9'(p), 64'h0010_0000 + 64'(p) * 64'h100);
        set_ptr(9'd40, 64'h0);
        ar_en = 1'b0;
        push(9'd20);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            check_eq("fifo_ready", 128'(fetch_ready_o), 128'(i < 8));
            push(9'(21 + i));
        end
        check_eq("fifo_full", 128'(fetch_ready_o), 128'd0);
        ar_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            deliver_one(k == 3, n);
            if (k < 8) check_eq("upd_to_ar", 128'(n), (k == 3) ? 128'd3 : 128'd2);
        end
        desc_ready_i = 1'b1;
        drain();
        push(9'd40);
        push(9'd23);
        drain();

        // Asynchronous reset while a descriptor is waiting in OUT with a full FIFO.
        desc_ready_i = 1'b0;
        set_ptr(9'd50, 64'h0000_0000_7700_0000);
        for (int p = 50; p <= 58; p++) push(9'(p));
        wait_desc("rst_out_valid");
        check_eq("pre_rst_full", 128'(fetch_ready_o), 128'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_desc_valid", 128'(desc_valid_o), 128'd0);
        check_eq("arst_arvalid", 128'(m_axi_arvalid), 128'd0);
        check_eq("arst_rready", 128'(m_axi_rready), 128'd0);
        check_eq("arst_fetch_ready", 128'(fetch_ready_o), 128'd1);
        ar_q.delete();
        desc_q.delete();
        outstanding = 0;
        stale_pend = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        saved = ar_cnt;
        repeat (6) @(posedge clk);
        #1;
        check_eq("fifo_empty_after_rst", 128'(ar_cnt), 128'(saved));
        desc_ready_i = 1'b1;
        push(9'd50);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
